// File: rtl/mem_access_unit_if.sv
// Bundles the execute-stage request/response handshake and the data-memory pins.
// slave is the load/store unit's view; master is the environment's view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int OFF_W  = 8
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_is_store;
  logic        [DATA_W-1:0] req_base;
  logic signed [OFF_W-1:0]  req_offset;
  logic        [DATA_W-1:0] req_wdata;
  logic        [3:0]        req_rd;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic        [DATA_W-1:0] rsp_data;
  logic        [3:0]        rsp_rd;
  logic                     rsp_is_store;
  logic                     rsp_fault;

  logic                     mem_st;
  logic        [ADDR_W-1:0] mem_addr;
  logic        [DATA_W-1:0] mem_wdata;
  logic        [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_is_store, rsp_fault,
    output mem_st, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_is_store, rsp_fault,
    input  mem_st, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a small word-addressed data memory:
// one request in, one memory access (unless out of range), one response out.
module mem_access_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int OFF_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]        rd_q;
  logic              fault_q, fault_d;
  logic              is_store_q;
  logic [DATA_W-1:0] ea_d;
  logic              accept;

  function automatic logic [DATA_W-1:0] eff_addr(
    input logic        [DATA_W-1:0] base,
    input logic signed [OFF_W-1:0]  off
  );
    logic signed [DATA_W-1:0] off_ext;
    off_ext = {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
    return base + off_ext;
  endfunction

  // Any set bit above the memory's address field means the word does not exist,
  // which also catches negative wrap-around.
  function automatic logic out_of_range(input logic [DATA_W-1:0] ea);
    return |ea[DATA_W-1:ADDR_W];
  endfunction

  assign bus.req_ready = (state_q == IDLE) & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  assign ea_d       = eff_addr(bus.req_base, bus.req_offset);
  assign fault_d    = out_of_range(ea_d);
  assign rsp_data_d = (is_store_q | fault_q) ? '0 : bus.mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      fault_q    <= 1'b0;
      is_store_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= ea_d[ADDR_W-1:0];
        wdata_q    <= bus.req_wdata;
        rd_q       <= bus.req_rd;
        fault_q    <= fault_d;
        is_store_q <= bus.req_is_store;
      end
      // Load data is sampled from the combinational read port on leaving EXEC.
      if (state_q == EXEC) rsp_data_q <= rsp_data_d;
    end
  end

  // Address/write-data simply hold the captured request, so they keep their
  // last value outside EXEC; the write strobe is confined to EXEC.
  assign bus.mem_st       = (state_q == EXEC) & is_store_q & ~fault_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;

  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_rd       = rd_q;
  assign bus.rsp_is_store = is_store_q;
  assign bus.rsp_fault    = fault_q;
endmodule
